pipeline_mem_stage: RTL and testbench
=====================================

Name: pipeline_mem_stage

Overview:
- EX/MEM pipeline register plus MEM stage; consumes every result the execute stage produces: ALU result, Rs2 store data, branch target, PC+4 and zero flag.
- Resolves branches and jumps, and drives the data-memory request/acknowledge handshake.
- Stalls upstream stages while an access is outstanding.
- Presents load data and pass-through results to the write-back register.

Parameters:
TIMEOUT_CYCLES, 255, max cycles mem_req may stay high without mem_ack before the access is aborted
CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
valid_in_MEM  in  1  EX holds a real instruction
PC_in_MEM  in  32  branch/jump target from EX
PC4_in_MEM  in  32  PC+4 from EX
zero_in_MEM  in  1  ALU zero flag
ALU_in_MEM  in  32  ALU result / memory address
Rs2_in_MEM  in  32  store data
MemRead_in_MEM  in  1  load
MemWrite_in_MEM  in  1  store
Branch_in_MEM  in  1  conditional branch
Jump_in_MEM  in  1  unconditional jump
RegWrite_in_MEM  in  1  write-back enable
MemtoReg_in_MEM  in  2  WB select: 0 ALU, 1 load data, 2 PC+4
Rd_in_MEM  in  5  destination register
mem_addr  out  32  data memory address
mem_wdata  out  32  store data
mem_we  out  1  1 = write access
mem_req  out  1  access request
mem_ack  in  1  access complete; mem_rdata valid in the same cycle
mem_rdata  in  32  load data
stall_out  out  1  freeze PC, IF/ID, ID/EX
PCSrc_out  out  1  redirect PC to PC_target_out
PC_target_out  out  32  latched branch target
flush_out  out  1  squash IF/ID and ID/EX
valid_out_MEM  out  1  instruction complete, valid for WB this cycle
ALU_out_MEM  out  32  latched ALU result
Data_out_MEM  out  32  captured load data
PC4_out_MEM  out  32  latched PC+4
RegWrite_out_MEM  out  1
MemtoReg_out_MEM  out  2
Rd_out_MEM  out  5
mem_err_out  out  1  sticky timeout flag

Behaviour:
- Reset: all registers, Data_out_MEM and the counter cleared to 0; state IDLE. Every output is 0 and mem_err_out is cleared.
- Capture: on a clk edge with rst=0 and stall_out=0, all *_in_MEM values are latched.
- Captured valid = valid_in_MEM & ~PCSrc_out, so a wrong-path instruction behind a taken branch becomes a bubble.
- While stall_out=1 the registers hold.
- Only a valid captured instruction with MemRead or MemWrite enters ACCESS.
- FSM IDLE: mem_req=0; on capture of a valid memory op, next state is ACCESS and the counter is cleared.
- FSM ACCESS:
  - mem_req=1, mem_addr=ALU_out_MEM, mem_wdata=Rs2 reg, mem_we=MemWrite reg.
  - Counter increments each cycle that mem_ack=0.
  - On mem_ack=1: a load latches mem_rdata into Data_out_MEM; go to IDLE, or stay in ACCESS if a new memory op is captured on the same edge.
  - On counter reaching TIMEOUT_CYCLES with mem_ack=0: mem_err_out is set (sticky), Data_out_MEM is set to 0, go to IDLE.
- mem_addr, mem_wdata and mem_we are 0 in IDLE. mem_req never drops before ack or timeout.
- stall_out = (state==ACCESS) & ~mem_ack & ~timeout_hit, combinational. The next instruction is captured on the completing edge, with no bubble.
- valid_out_MEM = valid reg & ~stall_out. Non-memory ops complete in 1 cycle; memory ops in 1 + wait cycles.
- Branch resolution:
  - PCSrc_out = valid reg & (Jump | (Branch & zero)), combinational from registered values; flush_out = PCSrc_out.
  - PC_target_out = latched PC_in_MEM.
  - Branch and jump never access memory.
- MemRead and MemWrite both set: treated as a store.
- rst during ACCESS: mem_req drops in the following cycle, the access is abandoned, and a late mem_ack is ignored in IDLE.
- mem_ack in IDLE: ignored.

Test Plan:
- ALU op: ALU_in=0x0000_0010, RegWrite=1, Rd=5, valid=1 -> next cycle valid_out_MEM=1, ALU_out_MEM=0x10, Rd_out=5, mem_req=0, stall_out=0.
- Load, 3-cycle wait: ALU_in=0x100, MemRead=1; mem_ack high on the 3rd ACCESS cycle with mem_rdata=0xDEADBEEF -> mem_req=1 for 3 cycles, mem_addr=0x100, stall_out=1 for 2 cycles, Data_out_MEM=0xDEADBEEF, valid_out_MEM=1 for exactly one cycle.
- Back-to-back stores with mem_ack tied to 1: store 0xAAAA at 0x4, then 0xBBBB at 0x8 -> two consecutive req cycles, mem_we=1, no stall.
- Taken branch: Branch=1, zero=1, PC_in=0x40, with a valid instruction behind it -> PCSrc_out=flush_out=1 for one cycle, PC_target_out=0x40, following captured valid=0.
- Not-taken branch: zero=0 -> PCSrc_out=0. Jump with zero=0 -> PCSrc_out=1.
- Timeout: load with mem_ack held 0 -> after 255 ACCESS cycles mem_req=0, mem_err_out=1, Data_out_MEM=0. mem_err_out stays set until rst.
- Reset mid-access: rst asserted during ACCESS -> all outputs 0 next cycle; a later mem_ack has no effect.

Source files
------------

// File: rtl/pipeline_mem_stage.sv
// ----------------------------------------------------------------------------
// pipeline_mem_stage
//
// Purpose:
//   EX/MEM pipeline register followed by the MEM stage of a 5-stage core.
//   Latches everything the execute stage produces and resolves branches and
//   jumps from the latched values. It runs the data-memory req/ack handshake,
//   holds the upstream stages while an access is outstanding, and aborts an
//   access that receives no acknowledge within TIMEOUT_CYCLES cycles.
//
// Parameters:
//   TIMEOUT_CYCLES : maximum number of cycles mem_req stays high without mem_ack
//   CNT_W          : timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports:
//   clk, rst            : rising-edge clock, synchronous active-high reset
//   *_in_MEM            : execute-stage results and control for the current op
//   mem_addr/wdata/we   : data-memory request payload, zero while idle
//   mem_req, mem_ack    : request / completion handshake (rdata valid with ack)
//   mem_rdata           : load data from memory
//   stall_out           : freezes PC, IF/ID and ID/EX while an access waits
//   PCSrc_out, flush_out: taken branch or jump, redirect PC and squash IF/ID, ID/EX
//   PC_target_out       : latched branch/jump target
//   valid_out_MEM       : instruction completes this cycle, valid for WB
//   *_out_MEM           : latched pass-through results and load data for WB
//   mem_err_out         : sticky access-timeout flag, cleared only by rst
// ----------------------------------------------------------------------------
module pipeline_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        valid_in_MEM,
    input  logic [31:0] PC_in_MEM,
    input  logic [31:0] PC4_in_MEM,
    input  logic        zero_in_MEM,
    input  logic [31:0] ALU_in_MEM,
    input  logic [31:0] Rs2_in_MEM,
    input  logic        MemRead_in_MEM,
    input  logic        MemWrite_in_MEM,
    input  logic        Branch_in_MEM,
    input  logic        Jump_in_MEM,
    input  logic        RegWrite_in_MEM,
    input  logic [1:0]  MemtoReg_in_MEM,
    input  logic [4:0]  Rd_in_MEM,

    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_req,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        stall_out,
    output logic        PCSrc_out,
    output logic [31:0] PC_target_out,
    output logic        flush_out,

    output logic        valid_out_MEM,
    output logic [31:0] ALU_out_MEM,
    output logic [31:0] Data_out_MEM,
    output logic [31:0] PC4_out_MEM,
    output logic        RegWrite_out_MEM,
    output logic [1:0]  MemtoReg_out_MEM,
    output logic [4:0]  Rd_out_MEM,
    output logic        mem_err_out
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Everything latched from EX in one register so capture/hold is a single decision.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_target;
        logic [31:0] pc4;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        reg_write;
        logic [1:0]  mem_to_reg;
        logic [4:0]  rd;
    } ex_mem_t;

    // Counter value on the last permitted waiting cycle: the increment on this
    // cycle would make the count reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ex_mem_t            ex_mem_q, ex_mem_d;
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic               err_q, err_d;

    logic               in_access;
    logic               timeout_hit;
    logic               cap_valid;
    logic               cap_mem_op;
    logic               is_load_q;

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    assign in_access   = (state_q == S_ACCESS);
    assign timeout_hit = in_access & ~mem_ack & (cnt_q == TIMEOUT_LAST);
    assign stall_out   = in_access & ~mem_ack & ~timeout_hit;

    // Branch resolution works purely on latched values, so it is stable all cycle.
    assign PCSrc_out     = ex_mem_q.valid & (ex_mem_q.jump | (ex_mem_q.branch & ex_mem_q.zero));
    assign flush_out     = PCSrc_out;
    assign PC_target_out = ex_mem_q.pc_target;

    // The instruction behind a taken branch is on the wrong path: latch it as a bubble.
    assign cap_valid  = valid_in_MEM & ~PCSrc_out;
    // Branches and jumps never touch memory even if their decode sets MemRead/MemWrite.
    assign cap_mem_op = cap_valid & (MemRead_in_MEM | MemWrite_in_MEM)
                        & ~Branch_in_MEM & ~Jump_in_MEM;

    // MemRead together with MemWrite is a store, so only a pure read returns data.
    assign is_load_q  = ex_mem_q.mem_read & ~ex_mem_q.mem_write;

    // ------------------------------------------------------------------------
    // Pipeline register next state: capture whenever the stage is not stalled
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        ex_mem_d = ex_mem_q;
        if (!stall_out) begin
            ex_mem_d.valid      = cap_valid;
            ex_mem_d.pc_target  = PC_in_MEM;
            ex_mem_d.pc4        = PC4_in_MEM;
            ex_mem_d.zero       = zero_in_MEM;
            ex_mem_d.alu        = ALU_in_MEM;
            ex_mem_d.rs2        = Rs2_in_MEM;
            ex_mem_d.mem_read   = MemRead_in_MEM;
            ex_mem_d.mem_write  = MemWrite_in_MEM;
            ex_mem_d.branch     = Branch_in_MEM;
            ex_mem_d.jump       = Jump_in_MEM;
            ex_mem_d.reg_write  = RegWrite_in_MEM;
            ex_mem_d.mem_to_reg = MemtoReg_in_MEM;
            ex_mem_d.rd         = Rd_in_MEM;
        end
    end

    // ------------------------------------------------------------------------
    // Access FSM next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                // A stray mem_ack while idle is ignored.
                if (cap_mem_op) begin
                    state_d = S_ACCESS;
                    cnt_d   = '0;
                end
            end

            S_ACCESS: begin
                if (mem_ack) begin
                    if (is_load_q) begin
                        data_d = mem_rdata;
                    end
                    // The next instruction is latched on this same edge; if it
                    // is a memory op its access starts immediately, no bubble.
                    state_d = cap_mem_op ? S_ACCESS : S_IDLE;
                    cnt_d   = '0;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    // The stall is released on the aborting edge too, so a
                    // memory op latched here still gets its own access.
                    state_d = cap_mem_op ? S_ACCESS : S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ex_mem_q <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            ex_mem_q <= ex_mem_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Memory interface: payload is forced to zero outside an access
    // ------------------------------------------------------------------------
    assign mem_req   = in_access;
    assign mem_addr  = in_access ? ex_mem_q.alu : 32'h0;
    assign mem_wdata = in_access ? ex_mem_q.rs2 : 32'h0;
    assign mem_we    = in_access & ex_mem_q.mem_write;

    // ------------------------------------------------------------------------
    // Write-back side
    // ------------------------------------------------------------------------
    assign valid_out_MEM    = ex_mem_q.valid & ~stall_out;
    assign ALU_out_MEM      = ex_mem_q.alu;
    assign Data_out_MEM     = data_q;
    assign PC4_out_MEM      = ex_mem_q.pc4;
    assign RegWrite_out_MEM = ex_mem_q.reg_write;
    assign MemtoReg_out_MEM = ex_mem_q.mem_to_reg;
    assign Rd_out_MEM       = ex_mem_q.rd;
    assign mem_err_out      = err_q;

endmodule

// File: tb/tb_pipeline_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_pipeline_mem_stage
//
// Table of per-cycle vectors (inputs plus expected outputs for that same
// cycle) for single-cycle ops, back-to-back stores and branch resolution,
// followed by hand-written sequences for the waited load, the access timeout
// and reset during an access.
// ----------------------------------------------------------------------------
module tb_pipeline_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in_MEM;
    logic [31:0] PC_in_MEM;
    logic [31:0] PC4_in_MEM;
    logic        zero_in_MEM;
    logic [31:0] ALU_in_MEM;
    logic [31:0] Rs2_in_MEM;
    logic        MemRead_in_MEM;
    logic        MemWrite_in_MEM;
    logic        Branch_in_MEM;
    logic        Jump_in_MEM;
    logic        RegWrite_in_MEM;
    logic [1:0]  MemtoReg_in_MEM;
    logic [4:0]  Rd_in_MEM;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_req;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall_out;
    logic        PCSrc_out;
    logic [31:0] PC_target_out;
    logic        flush_out;
    logic        valid_out_MEM;
    logic [31:0] ALU_out_MEM;
    logic [31:0] Data_out_MEM;
    logic [31:0] PC4_out_MEM;
    logic        RegWrite_out_MEM;
    logic [1:0]  MemtoReg_out_MEM;
    logic [4:0]  Rd_out_MEM;
    logic        mem_err_out;

    always #5 clk = ~clk;

    pipeline_mem_stage #(
        .TIMEOUT_CYCLES(255),
        .CNT_W         (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .valid_in_MEM    (valid_in_MEM),
        .PC_in_MEM       (PC_in_MEM),
        .PC4_in_MEM      (PC4_in_MEM),
        .zero_in_MEM     (zero_in_MEM),
        .ALU_in_MEM      (ALU_in_MEM),
        .Rs2_in_MEM      (Rs2_in_MEM),
        .MemRead_in_MEM  (MemRead_in_MEM),
        .MemWrite_in_MEM (MemWrite_in_MEM),
        .Branch_in_MEM   (Branch_in_MEM),
        .Jump_in_MEM     (Jump_in_MEM),
        .RegWrite_in_MEM (RegWrite_in_MEM),
        .MemtoReg_in_MEM (MemtoReg_in_MEM),
        .Rd_in_MEM       (Rd_in_MEM),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_we          (mem_we),
        .mem_req         (mem_req),
        .mem_ack         (mem_ack),
        .mem_rdata       (mem_rdata),
        .stall_out       (stall_out),
        .PCSrc_out       (PCSrc_out),
        .PC_target_out   (PC_target_out),
        .flush_out       (flush_out),
        .valid_out_MEM   (valid_out_MEM),
        .ALU_out_MEM     (ALU_out_MEM),
        .Data_out_MEM    (Data_out_MEM),
        .PC4_out_MEM     (PC4_out_MEM),
        .RegWrite_out_MEM(RegWrite_out_MEM),
        .MemtoReg_out_MEM(MemtoReg_out_MEM),
        .Rd_out_MEM      (Rd_out_MEM),
        .mem_err_out     (mem_err_out)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        zero;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic        mr;
        logic        mw;
        logic        br;
        logic        jp;
        logic        rw;
        logic [1:0]  mtr;
        logic [4:0]  rd;
        logic        ack;
        logic [31:0] rdata;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic        req;
        logic        stall;
        logic        pcsrc;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] target;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam int NVEC = 15;
    vec_t tbl [NVEC];

    int passed = 0;
    int total  = 0;

    function automatic in_t mk_in(input logic v, input logic [31:0] pc, input logic zero,
                                  input logic [31:0] alu, input logic [31:0] rs2,
                                  input logic mr, input logic mw, input logic br,
                                  input logic jp, input logic rw, input logic [4:0] rd,
                                  input logic ack, input logic [31:0] rdata);
        in_t x;
        x       = '0;
        x.v     = v;
        x.pc    = pc;
        x.zero  = zero;
        x.alu   = alu;
        x.rs2   = rs2;
        x.mr    = mr;
        x.mw    = mw;
        x.br    = br;
        x.jp    = jp;
        x.rw    = rw;
        x.rd    = rd;
        x.ack   = ack;
        x.rdata = rdata;
        return x;
    endfunction

    function automatic exp_t mk_exp(input logic valid, input logic req, input logic stall,
                                    input logic pcsrc, input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [31:0] target,
                                    input logic [31:0] alu, input logic [4:0] rd,
                                    input logic [31:0] data);
        exp_t e;
        e.valid  = valid;
        e.req    = req;
        e.stall  = stall;
        e.pcsrc  = pcsrc;
        e.we     = we;
        e.addr   = addr;
        e.wdata  = wdata;
        e.target = target;
        e.alu    = alu;
        e.rd     = rd;
        e.data   = data;
        return e;
    endfunction

    task automatic drive(input in_t x);
        valid_in_MEM    = x.v;
        PC_in_MEM       = x.pc;
        PC4_in_MEM      = x.pc4;
        zero_in_MEM     = x.zero;
        ALU_in_MEM      = x.alu;
        Rs2_in_MEM      = x.rs2;
        MemRead_in_MEM  = x.mr;
        MemWrite_in_MEM = x.mw;
        Branch_in_MEM   = x.br;
        Jump_in_MEM     = x.jp;
        RegWrite_in_MEM = x.rw;
        MemtoReg_in_MEM = x.mtr;
        Rd_in_MEM       = x.rd;
        mem_ack         = x.ack;
        mem_rdata       = x.rdata;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t         nop;
        in_t         x;
        logic [31:0] prev_pc4;
        logic        prev_rw;
        logic [1:0]  prev_mtr;
        int          req_n;
        int          stall_n;
        int          vld_n;
        logic        last_stall;
        logic        last_valid;
        logic        err_early;

        nop = mk_in(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 32'h0);

        //            v  pc         z  alu        rs2        mr mw br jp rw rd  ack rdata
        tbl[0]  = '{mk_in(1, 32'h0,  0, 32'h10,  32'h0,    0, 0, 0, 0, 1, 5, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[1]  = '{mk_in(1, 32'h0,  0, 32'h4,   32'hAAAA, 0, 1, 0, 0, 0, 0, 1, 32'h0),
                    mk_exp(1, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h10, 5, 32'h0)};
        tbl[2]  = '{mk_in(1, 32'h0,  0, 32'h8,   32'hBBBB, 0, 1, 0, 0, 0, 0, 1, 32'h0),
                    mk_exp(1, 1, 0, 0, 1, 32'h4,  32'hAAAA, 32'h0,   32'h4,  0, 32'h0)};
        tbl[3]  = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 1, 32'h0),
                    mk_exp(1, 1, 0, 0, 1, 32'h8,  32'hBBBB, 32'h0,   32'h8,  0, 32'h0)};
        tbl[4]  = '{mk_in(1, 32'h40, 1, 32'h0,   32'h0,    0, 0, 1, 0, 0, 0, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[5]  = '{mk_in(1, 32'h0,  0, 32'h77,  32'h0,    0, 0, 0, 0, 1, 7, 0, 32'h0),
                    mk_exp(1, 0, 0, 1, 0, 32'h0,  32'h0,    32'h40,  32'h0,  0, 32'h0)};
        tbl[6]  = '{mk_in(1, 32'h80, 0, 32'h0,   32'h0,    0, 0, 1, 0, 0, 0, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h77, 7, 32'h0)};
        tbl[7]  = '{mk_in(1, 32'hC0, 0, 32'h0,   32'h0,    0, 0, 0, 1, 0, 0, 0, 32'h0),
                    mk_exp(1, 0, 0, 0, 0, 32'h0,  32'h0,    32'h80,  32'h0,  0, 32'h0)};
        tbl[8]  = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0),
                    mk_exp(1, 0, 0, 1, 0, 32'h0,  32'h0,    32'hC0,  32'h0,  0, 32'h0)};
        tbl[9]  = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 1, 32'h1234),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[10] = '{mk_in(1, 32'h0,  0, 32'h20,  32'h55,   1, 1, 0, 0, 0, 0, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[11] = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 1, 32'hCAFE),
                    mk_exp(1, 1, 0, 0, 1, 32'h20, 32'h55,   32'h0,   32'h20, 0, 32'h0)};
        tbl[12] = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[13] = '{mk_in(1, 32'h100, 0, 32'h30, 32'h66,   0, 1, 1, 0, 0, 0, 0, 32'h0),
                    mk_exp(0, 0, 0, 0, 0, 32'h0,  32'h0,    32'h0,   32'h0,  0, 32'h0)};
        tbl[14] = '{mk_in(0, 32'h0,  0, 32'h0,   32'h0,    0, 0, 0, 0, 0, 0, 0, 32'h0),
                    mk_exp(1, 0, 0, 0, 0, 32'h0,  32'h0,    32'h100, 32'h30, 0, 32'h0)};

        // ---------------- reset with junk on every input ----------------
        rst = 1'b1;
        x = mk_in(1'b1, 32'hFFFF_FFFF, 1'b1, 32'hFFFF, 32'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1,
                  5'd31, 1'b1, 32'hFFFF_FFFF);
        x.pc4 = 32'hFFFF_FFFF;
        x.mtr = 2'd3;
        drive(x);
        tick();
        tick();
        check("rst valid_out", 32'(valid_out_MEM), 32'd0);
        check("rst mem_req",   32'(mem_req),       32'd0);
        check("rst stall",     32'(stall_out),     32'd0);
        check("rst pcsrc",     32'(PCSrc_out),     32'd0);
        check("rst flush",     32'(flush_out),     32'd0);
        check("rst target",    PC_target_out,      32'h0);
        check("rst alu_out",   ALU_out_MEM,        32'h0);
        check("rst data_out",  Data_out_MEM,       32'h0);
        check("rst pc4_out",   PC4_out_MEM,        32'h0);
        check("rst regwrite",  32'(RegWrite_out_MEM), 32'd0);
        check("rst memtoreg",  32'(MemtoReg_out_MEM), 32'd0);
        check("rst rd_out",    32'(Rd_out_MEM),    32'd0);
        check("rst err",       32'(mem_err_out),   32'd0);
        check("rst addr",      mem_addr,           32'h0);
        check("rst we",        32'(mem_we),        32'd0);
        check("rst wdata",     mem_wdata,          32'h0);
        rst = 1'b0;

        // ---------------- table-driven single-cycle behaviour ----------------
        prev_pc4 = 32'h0;
        prev_rw  = 1'b0;
        prev_mtr = 2'd0;
        for (int i = 0; i < NVEC; i++) begin
            x     = tbl[i].i;
            x.pc4 = 32'h1000 + 32'(i) * 32'd4;
            x.mtr = 2'(i);
            drive(x);
            #1;
            check($sformatf("r%0d valid_out", i), 32'(valid_out_MEM), 32'(tbl[i].e.valid));
            check($sformatf("r%0d mem_req", i),   32'(mem_req),       32'(tbl[i].e.req));
            check($sformatf("r%0d stall", i),     32'(stall_out),     32'(tbl[i].e.stall));
            check($sformatf("r%0d pcsrc", i),     32'(PCSrc_out),     32'(tbl[i].e.pcsrc));
            check($sformatf("r%0d flush", i),     32'(flush_out),     32'(tbl[i].e.pcsrc));
            check($sformatf("r%0d mem_we", i),    32'(mem_we),        32'(tbl[i].e.we));
            check($sformatf("r%0d mem_addr", i),  mem_addr,           tbl[i].e.addr);
            check($sformatf("r%0d mem_wdata", i), mem_wdata,          tbl[i].e.wdata);
            check($sformatf("r%0d target", i),    PC_target_out,      tbl[i].e.target);
            check($sformatf("r%0d alu_out", i),   ALU_out_MEM,        tbl[i].e.alu);
            check($sformatf("r%0d rd_out", i),    32'(Rd_out_MEM),    32'(tbl[i].e.rd));
            check($sformatf("r%0d data_out", i),  Data_out_MEM,       tbl[i].e.data);
            check($sformatf("r%0d pc4_out", i),   PC4_out_MEM,        prev_pc4);
            check($sformatf("r%0d regwrite", i),  32'(RegWrite_out_MEM), 32'(prev_rw));
            check($sformatf("r%0d memtoreg", i),  32'(MemtoReg_out_MEM), 32'(prev_mtr));
            check($sformatf("r%0d err", i),       32'(mem_err_out),   32'd0);
            prev_pc4 = x.pc4;
            prev_rw  = x.rw;
            prev_mtr = x.mtr;
            tick();
        end

        // ---------------- load with ack on the 3rd access cycle ----------------
        x = nop;
        x.v = 1'b1; x.alu = 32'h100; x.mr = 1'b1; x.rw = 1'b1; x.rd = 5'd3; x.mtr = 2'd1;
        drive(x);
        #1;
        check("ld idle mem_req", 32'(mem_req), 32'd0);
        tick();
        req_n = 0; stall_n = 0; vld_n = 0;
        for (int k = 0; k < 3; k++) begin
            // An ALU op waits in EX behind the load and must enter on the completing edge.
            x = nop;
            x.v = 1'b1; x.alu = 32'h99; x.rw = 1'b1; x.rd = 5'd9;
            x.ack   = (k == 2);
            x.rdata = (k == 2) ? 32'hDEAD_BEEF : 32'h0;
            drive(x);
            #1;
            req_n   += int'(mem_req);
            stall_n += int'(stall_out);
            vld_n   += int'(valid_out_MEM);
            check($sformatf("ld c%0d addr", k),     mem_addr,               32'h100);
            check($sformatf("ld c%0d we", k),       32'(mem_we),            32'd0);
            check($sformatf("ld c%0d alu hold", k), ALU_out_MEM,            32'h100);
            check($sformatf("ld c%0d mtr hold", k), 32'(MemtoReg_out_MEM),  32'd1);
            tick();
        end
        drive(nop);
        #1;
        check("ld req cycles",      32'(req_n),          32'd3);
        check("ld stall cycles",    32'(stall_n),        32'd2);
        check("ld valid cycles",    32'(vld_n),          32'd1);
        check("ld data_out",        Data_out_MEM,        32'hDEAD_BEEF);
        check("ld after req",       32'(mem_req),        32'd0);
        check("ld next valid",      32'(valid_out_MEM),  32'd1);
        check("ld next alu_out",    ALU_out_MEM,         32'h99);
        check("ld next rd_out",     32'(Rd_out_MEM),     32'd9);
        tick();

        // ---------------- access timeout ----------------
        x = nop;
        x.v = 1'b1; x.alu = 32'h200; x.mr = 1'b1; x.rw = 1'b1; x.rd = 5'd4;
        drive(x);
        #1;
        tick();
        req_n = 0; last_stall = 1'b1; last_valid = 1'b0; err_early = 1'b0;
        for (int k = 0; k < 400; k++) begin
            drive(nop);
            #1;
            if (!mem_req) break;
            req_n++;
            last_stall = stall_out;
            last_valid = valid_out_MEM;
            if (mem_err_out) err_early = 1'b1;
            tick();
        end
        check("to req cycles",     32'(req_n),         32'd255);
        check("to last stall",     32'(last_stall),    32'd0);
        check("to last valid",     32'(last_valid),    32'd1);
        check("to err early",      32'(err_early),     32'd0);
        check("to err set",        32'(mem_err_out),   32'd1);
        check("to data cleared",   Data_out_MEM,       32'h0);
        check("to stall after",    32'(stall_out),     32'd0);
        check("to addr idle",      mem_addr,           32'h0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(nop);
            #1;
            tick();
        end
        drive(nop);
        #1;
        check("to err sticky",     32'(mem_err_out),   32'd1);
        tick();

        // ---------------- reset in the middle of an access ----------------
        x = nop;
        x.v = 1'b1; x.alu = 32'h300; x.mr = 1'b1; x.rw = 1'b1; x.rd = 5'd6;
        x.pc4 = 32'h3004; x.mtr = 2'd1;
        drive(x);
        #1;
        tick();
        drive(nop);
        #1;
        check("rm in access",      32'(mem_req),       32'd1);
        check("rm err before",     32'(mem_err_out),   32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        x = nop;
        x.ack = 1'b1; x.rdata = 32'h5555;
        drive(x);
        #1;
        check("rm mem_req",        32'(mem_req),       32'd0);
        check("rm addr",           mem_addr,           32'h0);
        check("rm we",             32'(mem_we),        32'd0);
        check("rm stall",          32'(stall_out),     32'd0);
        check("rm valid_out",      32'(valid_out_MEM), 32'd0);
        check("rm alu_out",        ALU_out_MEM,        32'h0);
        check("rm rd_out",         32'(Rd_out_MEM),    32'd0);
        check("rm pc4_out",        PC4_out_MEM,        32'h0);
        check("rm regwrite",       32'(RegWrite_out_MEM), 32'd0);
        check("rm memtoreg",       32'(MemtoReg_out_MEM), 32'd0);
        check("rm err cleared",    32'(mem_err_out),   32'd0);
        check("rm data_out",       Data_out_MEM,       32'h0);
        tick();
        drive(nop);
        #1;
        check("rm late ack data",  Data_out_MEM,       32'h0);
        check("rm late ack req",   32'(mem_req),       32'd0);
        check("rm late ack err",   32'(mem_err_out),   32'd0);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
